// File: rtl/cache_control_pkg.sv
// Mux-select encodings for the cache datapath and the controller's shared
// types: FSM state enum, tree-PLRU helpers, way-index to select conversions.

package wemux;
    typedef enum logic [1:0] {
        zeros = 2'd0,
        ones  = 2'd1,
        mbe   = 2'd2
    } wemux_sel_t;
endpackage

package dimux;
    typedef enum logic {
        mem_wdata256_from_cpu = 1'b0,
        pmem_rdata_from_mem   = 1'b1
    } dimux_sel_t;
endpackage

package domux;
    typedef enum logic [2:0] {
        zeros        = 3'd0,
        data_array_0 = 3'd1,
        data_array_1 = 3'd2,
        data_array_2 = 3'd3,
        data_array_3 = 3'd4
    } domux_sel_t;
endpackage

package addrmux;
    typedef enum logic [2:0] {
        from_cpu = 3'd0,
        cache_0  = 3'd1,
        cache_1  = 3'd2,
        cache_2  = 3'd3,
        cache_3  = 3'd4
    } addrmux_sel_t;
endpackage

package cache_ctrl_types;
    import wemux::wemux_sel_t;
    import dimux::dimux_sel_t;
    import domux::domux_sel_t;
    import addrmux::addrmux_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cache_state_t;

    // lru[0] picks the half, lru[1]/lru[2] pick the way inside it
    function automatic logic [1:0] plru_victim(input logic [2:0] lru);
        return lru[0] ? {1'b1, lru[2]} : {1'b0, lru[1]};
    endfunction

    // Point the tree away from the way just accessed
    function automatic logic [2:0] plru_update(input logic [2:0] lru,
                                               input logic [1:0] way);
        logic [2:0] nxt;
        nxt    = lru;
        nxt[0] = (way < 2'd2);
        if (way < 2'd2)
            nxt[1] = (way == 2'd0);
        else
            nxt[2] = (way == 2'd2);
        return nxt;
    endfunction

    // Data-array output select follows way order after the zeros encoding
    function automatic domux_sel_t do_sel_of(input logic [1:0] way);
        return domux_sel_t'({1'b0, way} + 3'd1);
    endfunction

    function automatic addrmux_sel_t addr_sel_of(input logic [1:0] way);
        return addrmux_sel_t'({1'b0, way} + 3'd1);
    endfunction
endpackage

// File: rtl/cache_control_plru.sv
// Combinational replacement logic: victim choice (first invalid way, else
// the tree-PLRU victim) and the PLRU bits after an access.

module cache_plru
    import cache_ctrl_types::*;
(
    input  logic [3:0] valid,
    input  logic [2:0] lru,
    input  logic [1:0] access_way,
    output logic [1:0] victim,
    output logic [2:0] lru_next
);

    // Invalid ways are free, so fill them before evicting anything
    always_comb begin
        victim = plru_victim(lru);
        casez (valid)
            4'b???0: victim = 2'd0;
            4'b??01: victim = 2'd1;
            4'b?011: victim = 2'd2;
            4'b0111: victim = 2'd3;
            default: victim = plru_victim(lru);
        endcase
    end

    // Tree update for the way being hit
    always_comb begin
        lru_next = plru_update(lru, access_way);
    end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 4-way set-associative cache: hit service,
// dirty write-back, then line allocate.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a CPU read or write
// CHECK     | arrays valid; respond on hit, else pick and latch victim
// WRITEBACK | writing dirty victim line to physical memory
// ALLOCATE  | fetching the requested line into the victim way

module cache_control
    import cache_ctrl_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            hit,
    input  logic [3:0]            valid,
    input  logic [3:0]            dirty,
    input  logic [2:0]            lru,
    input  logic                  pmem_resp,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output wemux::wemux_sel_t     we_sel [4],
    output dimux::dimux_sel_t     di_sel,
    output domux::domux_sel_t     do_sel,
    output addrmux::addrmux_sel_t addr_sel,
    output logic [3:0]            load_tag,
    output logic [3:0]            load_valid,
    output logic [3:0]            load_dirty,
    output logic                  valid_in,
    output logic                  dirty_in,
    output logic                  load_lru,
    output logic [2:0]            lru_in
);

    cache_state_t state, state_next;
    logic [1:0]   victim, victim_next;
    logic [1:0]   victim_pick;
    logic [1:0]   hit_way;
    logic [2:0]   lru_next;

    // Multi-hot hit is a datapath fault; lowest way wins deterministically
    always_comb begin
        hit_way = 2'd0;
        casez (hit)
            4'b???1: hit_way = 2'd0;
            4'b??10: hit_way = 2'd1;
            4'b?100: hit_way = 2'd2;
            4'b1000: hit_way = 2'd3;
            default: hit_way = 2'd0;
        endcase
    end

    cache_plru u_plru (
        .valid      (valid),
        .lru        (lru),
        .access_way (hit_way),
        .victim     (victim_pick),
        .lru_next   (lru_next)
    );

    // State and latched victim way
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            victim <= 2'd0;
        end else begin
            state  <= state_next;
            victim <= victim_next;
        end
    end

    // Next-state and datapath controls
    always_comb begin
        state_next  = state;
        victim_next = victim;
        mem_resp    = 1'b0;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        for (int i = 0; i < 4; i++) we_sel[i] = wemux::zeros;
        di_sel      = dimux::mem_wdata256_from_cpu;
        do_sel      = domux::zeros;
        addr_sel    = addrmux::from_cpu;
        load_tag    = 4'b0000;
        load_valid  = 4'b0000;
        load_dirty  = 4'b0000;
        valid_in    = 1'b0;
        dirty_in    = 1'b0;
        load_lru    = 1'b0;
        lru_in      = 3'b000;

        case (state)
            IDLE: begin
                if (mem_read || mem_write) state_next = CHECK;
            end
            CHECK: begin
                if (|hit) begin
                    mem_resp = 1'b1;
                    do_sel   = do_sel_of(hit_way);
                    load_lru = 1'b1;
                    lru_in   = lru_next;
                    if (mem_write) begin
                        we_sel[hit_way]     = wemux::mbe;
                        load_dirty[hit_way] = 1'b1;
                        dirty_in            = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    victim_next = victim_pick;
                    state_next  = dirty[victim_pick] ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = addr_sel_of(victim);
                do_sel     = do_sel_of(victim);
                if (pmem_resp) begin
                    load_dirty[victim] = 1'b1;
                    dirty_in           = 1'b0;
                    state_next         = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                addr_sel  = addrmux::from_cpu;
                if (pmem_resp) begin
                    di_sel             = dimux::pmem_rdata_from_mem;
                    we_sel[victim]     = wemux::ones;
                    load_tag[victim]   = 1'b1;
                    load_valid[victim] = 1'b1;
                    load_dirty[victim] = 1'b1;
                    valid_in           = 1'b1;
                    dirty_in           = 1'b0;
                    state_next         = CHECK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, multi-hot hit, clean and dirty
// misses, reset during allocate, stray pmem_resp in IDLE.

module tb_cache_control;
    import cache_ctrl_types::*;

    logic                  clk;
    logic                  rst;
    logic                  mem_read;
    logic                  mem_write;
    logic [3:0]            hit;
    logic [3:0]            valid;
    logic [3:0]            dirty;
    logic [2:0]            lru;
    logic                  pmem_resp;
    logic                  mem_resp;
    logic                  pmem_read;
    logic                  pmem_write;
    wemux::wemux_sel_t     we_sel [4];
    dimux::dimux_sel_t     di_sel;
    domux::domux_sel_t     do_sel;
    addrmux::addrmux_sel_t addr_sel;
    logic [3:0]            load_tag;
    logic [3:0]            load_valid;
    logic [3:0]            load_dirty;
    logic                  valid_in;
    logic                  dirty_in;
    logic                  load_lru;
    logic [2:0]            lru_in;

    int checks   = 0;
    int failures = 0;

    cache_control dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .hit        (hit),
        .valid      (valid),
        .dirty      (dirty),
        .lru        (lru),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .we_sel     (we_sel),
        .di_sel     (di_sel),
        .do_sel     (do_sel),
        .addr_sel   (addr_sel),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .valid_in   (valid_in),
        .dirty_in   (dirty_in),
        .load_lru   (load_lru),
        .lru_in     (lru_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // we_sel packed as {way3, way2, way1, way0}, 2 bits each
    function automatic logic [7:0] we_pack();
        return {we_sel[3], we_sel[2], we_sel[1], we_sel[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0;
        valid = 4'b1111; dirty = 4'b0; lru = 3'b0; pmem_resp = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_val("rst_mem_resp", mem_resp, 0);
        check_val("rst_pmem_rd", pmem_read, 0);
        check_val("rst_pmem_wr", pmem_write, 0);
        check_val("rst_we", we_pack(), 8'h00);
        check_val("rst_di", di_sel, dimux::mem_wdata256_from_cpu);
        check_val("rst_do", do_sel, domux::zeros);
        check_val("rst_addr", addr_sel, addrmux::from_cpu);
        check_val("rst_loads", {load_tag, load_valid, load_dirty, load_lru}, 0);
        check_val("rst_lru_in", lru_in, 0);
        check_val("rst_state", dut.state, IDLE);
        tick(); tick();
        rst = 1'b0;

        // read hit way 2, lru 000 -> lru_in 100
        mem_read = 1'b1;
        #1 check_val("rh_idle_resp", mem_resp, 0);
        tick();
        hit = 4'b0100; lru = 3'b000;
        #1;
        check_val("rh_resp", mem_resp, 1);
        check_val("rh_do", do_sel, domux::data_array_2);
        check_val("rh_load_lru", load_lru, 1);
        check_val("rh_lru_in", lru_in, 3'b100);
        check_val("rh_pmem", {pmem_read, pmem_write}, 0);
        check_val("rh_we", we_pack(), 8'h00);
        check_val("rh_ldirty", load_dirty, 0);
        tick();
        mem_read = 1'b0; hit = 4'b0;
        #1;
        check_val("rh_back_idle", dut.state, IDLE);
        check_val("rh_resp_drop", mem_resp, 0);

        // write hit way 0, lru 000 -> lru_in 011
        mem_write = 1'b1;
        tick();
        hit = 4'b0001;
        #1;
        check_val("wh_resp", mem_resp, 1);
        check_val("wh_we", we_pack(), 8'b0000_0010);
        check_val("wh_ldirty", load_dirty, 4'b0001);
        check_val("wh_dirty_in", dirty_in, 1);
        check_val("wh_lru_in", lru_in, 3'b011);
        check_val("wh_do", do_sel, domux::data_array_0);
        tick();
        mem_write = 1'b0; hit = 4'b0;

        // multi-hot hit 0110: way 1 wins, lru 000 -> 001
        mem_read = 1'b1;
        tick();
        hit = 4'b0110;
        #1;
        check_val("mh_do", do_sel, domux::data_array_1);
        check_val("mh_lru_in", lru_in, 3'b001);
        tick();
        mem_read = 1'b0; hit = 4'b0;

        // clean miss, valid 1011 -> victim 2, pmem_resp on 5th allocate cycle
        valid = 4'b1011; dirty = 4'b0000; lru = 3'b000; mem_read = 1'b1;
        tick();
        #1;
        check_val("cm_chk_resp", mem_resp, 0);
        check_val("cm_chk_pmem", pmem_read, 0);
        tick();
        #1;
        check_val("cm_state", dut.state, ALLOCATE);
        check_val("cm_victim", dut.victim, 2);
        check_val("cm_addr", addr_sel, addrmux::from_cpu);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check_val("cm_pmem_rd_hold", pmem_read, 1);
        end
        tick();
        pmem_resp = 1'b1;
        #1;
        check_val("cm_ltag", load_tag, 4'b0100);
        check_val("cm_lvalid", load_valid, 4'b0100);
        check_val("cm_ldirty", load_dirty, 4'b0100);
        check_val("cm_vin_din", {valid_in, dirty_in}, 2'b10);
        check_val("cm_di", di_sel, dimux::pmem_rdata_from_mem);
        check_val("cm_we", we_pack(), 8'b0001_0000);
        tick();
        pmem_resp = 1'b0; hit = 4'b0100; valid = 4'b1111;
        #1;
        check_val("cm_state_chk", dut.state, CHECK);
        check_val("cm_resp", mem_resp, 1);
        tick();
        mem_read = 1'b0; hit = 4'b0;

        // dirty miss, all valid, lru 101 -> victim 3
        valid = 4'b1111; dirty = 4'b1000; lru = 3'b101; mem_read = 1'b1;
        tick();
        tick();
        #1;
        check_val("dm_state", dut.state, WRITEBACK);
        check_val("dm_pmem_wr", pmem_write, 1);
        check_val("dm_pmem_rd", pmem_read, 0);
        check_val("dm_addr", addr_sel, addrmux::cache_3);
        check_val("dm_do", do_sel, domux::data_array_3);
        tick();
        pmem_resp = 1'b1;
        #1;
        check_val("dm_wb_ldirty", load_dirty, 4'b1000);
        check_val("dm_wb_din", dirty_in, 0);
        tick();
        pmem_resp = 1'b0;
        #1;
        check_val("dm_alloc_rd", {pmem_read, pmem_write}, 2'b10);
        tick();
        pmem_resp = 1'b1;
        #1;
        check_val("dm_ltag", load_tag, 4'b1000);
        check_val("dm_lvalid", load_valid, 4'b1000);
        check_val("dm_we", we_pack(), 8'b0100_0000);
        tick();
        pmem_resp = 1'b0; hit = 4'b1000;
        #1;
        check_val("dm_resp", mem_resp, 1);
        check_val("dm_lru_in", lru_in, 3'b000);
        check_val("dm_we_read", we_pack(), 8'h00);
        tick();
        mem_read = 1'b0; hit = 4'b0;

        // reset during allocate (victim 1 from lru 010)
        valid = 4'b1111; dirty = 4'b0000; lru = 3'b010; mem_read = 1'b1;
        tick();
        tick();
        #1;
        check_val("ra_pmem_rd", pmem_read, 1);
        check_val("ra_victim", dut.victim, 1);
        rst = 1'b1;
        #1;
        check_val("ra_pmem_drop", pmem_read, 0);
        check_val("ra_state", dut.state, IDLE);
        check_val("ra_victim_clr", dut.victim, 0);
        check_val("ra_addr", addr_sel, addrmux::from_cpu);
        mem_read = 1'b0;
        tick();
        rst = 1'b0;
        lru = 3'b000; mem_read = 1'b1;
        tick();
        hit = 4'b0010;
        #1;
        check_val("ra_fresh_resp", mem_resp, 1);
        check_val("ra_fresh_lru", lru_in, 3'b001);
        tick();
        mem_read = 1'b0; hit = 4'b0;

        // stray pmem_resp in IDLE
        pmem_resp = 1'b1;
        #1;
        check_val("sr_loads", {load_tag, load_valid, load_dirty}, 0);
        check_val("sr_we", we_pack(), 8'h00);
        tick();
        #1;
        check_val("sr_state", dut.state, IDLE);
        check_val("sr_pmem", {pmem_read, pmem_write}, 0);
        pmem_resp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
